// File: rtl/holy_core_pkg.sv
// Shared AXI response/burst encodings and the RAM slave state type.
package holy_core_pkg;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t  AXI_OKAY       = 2'b00;
   localparam axi_resp_t  AXI_SLVERR     = 2'b10;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

   typedef enum logic [2:0] {
      IDLE,
      W_DATA,
      W_RESP,
      R_FETCH,
      R_DATA
   } slave_state_t;

   // Only full-word incrementing bursts are served without error.
   function automatic logic burst_supported(input logic [1:0] burst, input logic [2:0] size);
      return (burst == AXI_BURST_INCR) && (size == AXI_SIZE_WORD);
   endfunction

endpackage

// File: rtl/holy_bram.sv
// Single-port byte-writable RAM with a registered read port (read-first).
// Each byte lane is its own array so the per-byte write enable maps onto BRAM.
module holy_bram #(
   parameter int MEM_WORDS = 4096,
   parameter int AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [MEM_WORDS];
         logic [7:0] q_reg;

         always_ff @(posedge clk) begin
            if (we[gi]) begin
               mem[addr] <= wdata[gi*8 +: 8];
            end
            q_reg <= mem[addr];
         end

         assign rdata[gi*8 +: 8] = q_reg;
      end
   endgenerate

endmodule

// File: rtl/holy_axi_ram_slave.sv
// AXI4 burst slave over on-chip RAM for holy_core: one transaction at a time,
// INCR word bursts, SLVERR for out-of-range or unsupported bursts.
module holy_axi_ram_slave
   import holy_core_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    ID_WIDTH   = 4,
   parameter int                    MEM_WORDS  = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_WIDTH-1:0]     s_awid,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr,
   input  logic [7:0]              s_awlen,
   input  logic [2:0]              s_awsize,
   input  logic [1:0]              s_awburst,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_wlast,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [ID_WIDTH-1:0]     s_bid,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [ID_WIDTH-1:0]     s_arid,
   input  logic [ADDR_WIDTH-1:0]   s_araddr,
   input  logic [7:0]              s_arlen,
   input  logic [2:0]              s_arsize,
   input  logic [1:0]              s_arburst,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [ID_WIDTH-1:0]     s_rid,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rlast,
   output logic                    s_rvalid,
   input  logic                    s_rready
);

   localparam int            AW       = $clog2(MEM_WORDS);
   localparam logic [AW-1:0] ONE_WORD = 1;

   slave_state_t          state_reg;
   logic [ID_WIDTH-1:0]   id_reg;
   logic [AW-1:0]         addr_reg;
   logic [7:0]            len_reg;
   logic [7:0]            cnt_reg;
   logic                  bad_reg;
   logic                  err_reg;
   logic                  awready_reg;
   logic                  arready_reg;
   logic                  wready_reg;
   logic                  bvalid_reg;
   logic                  rvalid_reg;
   logic                  rlast_reg;
   axi_resp_t             bresp_reg;
   axi_resp_t             rresp_reg;

   logic                  aw_hs, ar_hs, w_hs, r_hs;
   logic                  last_beat;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [ADDR_WIDTH:0]   req_diff;
   logic                  req_ok;
   logic [AW-1:0]         req_word;
   logic [3:0]            ram_we;
   logic [AW-1:0]         ram_addr;
   logic [31:0]           ram_q;

   assign aw_hs     = s_awvalid & awready_reg;
   assign ar_hs     = s_arvalid & arready_reg & ~s_awvalid;
   assign w_hs      = s_wvalid & wready_reg;
   assign r_hs      = rvalid_reg & s_rready;
   assign last_beat = (cnt_reg == len_reg);

   // The write wins when both address channels are valid, so decode its address.
   // A borrow from the extra top bit also lands in the range test below.
   assign req_addr = s_awvalid ? s_awaddr : s_araddr;
   assign req_diff = {1'b0, req_addr} - {1'b0, BASE_ADDR};
   assign req_word = req_diff[AW+1:2];
   assign req_ok   = ((req_diff >> (AW + 2)) == '0) &&
                     (s_awvalid ? burst_supported(s_awburst, s_awsize)
                                : burst_supported(s_arburst, s_arsize));

   // Advancing the RAM address on a read handshake prefetches the next beat.
   assign ram_we   = (w_hs && !bad_reg) ? s_wstrb : 4'b0000;
   assign ram_addr = r_hs ? addr_reg + ONE_WORD : addr_reg;

   holy_bram #(
      .MEM_WORDS (MEM_WORDS),
      .AW        (AW)
   ) u_bram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (s_wdata),
      .rdata (ram_q)
   );

   assign s_awready = awready_reg;
   assign s_arready = arready_reg & ~s_awvalid;
   assign s_wready  = wready_reg;
   assign s_bid     = id_reg;
   assign s_bresp   = bresp_reg;
   assign s_bvalid  = bvalid_reg;
   assign s_rid     = id_reg;
   assign s_rdata   = (rvalid_reg && !bad_reg) ? ram_q : '0;
   assign s_rresp   = rresp_reg;
   assign s_rlast   = rlast_reg;
   assign s_rvalid  = rvalid_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         id_reg      <= '0;
         addr_reg    <= '0;
         len_reg     <= '0;
         cnt_reg     <= '0;
         bad_reg     <= 1'b0;
         err_reg     <= 1'b0;
         awready_reg <= 1'b0;
         arready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         bvalid_reg  <= 1'b0;
         rvalid_reg  <= 1'b0;
         rlast_reg   <= 1'b0;
         bresp_reg   <= AXI_OKAY;
         rresp_reg   <= AXI_OKAY;
      end else begin
         case (state_reg)
            IDLE: begin
               awready_reg <= 1'b1;
               arready_reg <= 1'b1;
               if (aw_hs || ar_hs) begin
                  addr_reg    <= req_word;
                  cnt_reg     <= '0;
                  bad_reg     <= !req_ok;
                  err_reg     <= 1'b0;
                  awready_reg <= 1'b0;
                  arready_reg <= 1'b0;
               end
               if (aw_hs) begin
                  id_reg     <= s_awid;
                  len_reg    <= s_awlen;
                  wready_reg <= 1'b1;
                  state_reg  <= W_DATA;
               end else if (ar_hs) begin
                  id_reg    <= s_arid;
                  len_reg   <= s_arlen;
                  rresp_reg <= req_ok ? AXI_OKAY : AXI_SLVERR;
                  state_reg <= R_FETCH;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  addr_reg <= addr_reg + ONE_WORD;
                  cnt_reg  <= cnt_reg + 8'd1;
                  if (s_wlast != last_beat) begin
                     err_reg <= 1'b1;
                  end
                  if (last_beat) begin
                     wready_reg <= 1'b0;
                     bvalid_reg <= 1'b1;
                     bresp_reg  <= (bad_reg || err_reg || !s_wlast) ? AXI_SLVERR : AXI_OKAY;
                     state_reg  <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_bready) begin
                  bvalid_reg  <= 1'b0;
                  awready_reg <= 1'b1;
                  arready_reg <= 1'b1;
                  state_reg   <= IDLE;
               end
            end
            R_FETCH: begin
               rvalid_reg <= 1'b1;
               rlast_reg  <= (len_reg == 8'd0);
               state_reg  <= R_DATA;
            end
            R_DATA: begin
               if (s_rready) begin
                  if (last_beat) begin
                     rvalid_reg  <= 1'b0;
                     rlast_reg   <= 1'b0;
                     awready_reg <= 1'b1;
                     arready_reg <= 1'b1;
                     state_reg   <= IDLE;
                  end else begin
                     addr_reg  <= addr_reg + ONE_WORD;
                     cnt_reg   <= cnt_reg + 8'd1;
                     rlast_reg <= ((cnt_reg + 8'd1) == len_reg);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_holy_axi_ram_slave.sv
// Directed bench for holy_axi_ram_slave: bursts, strobes, backpressure,
// write/read arbitration, error responses, address wrap and async reset.
module tb_holy_axi_ram_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  s_awid,  s_arid,  s_bid,  s_rid;
   logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
   logic [7:0]  s_awlen, s_arlen;
   logic [2:0]  s_awsize, s_arsize;
   logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
   logic [3:0]  s_wstrb;
   logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
   logic        s_bvalid, s_bready, s_arvalid, s_arready;
   logic        s_rlast, s_rvalid, s_rready;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rd_data [256];
   logic        rd_last [256];
   logic [1:0]  rd_resp [256];
   logic [3:0]  rd_id;
   int          rd_n, rd_first, rd_lastcyc, rd_stall_err, rd_extra;
   logic [1:0]  b_resp;
   logic [3:0]  b_id;
   int          b_wait;
   logic        ar_watch = 1'b0;
   int          ar_early = 0;

   holy_axi_ram_slave dut (
      .clk       (clk),
      .rst       (rst),
      .s_awid    (s_awid),
      .s_awaddr  (s_awaddr),
      .s_awlen   (s_awlen),
      .s_awsize  (s_awsize),
      .s_awburst (s_awburst),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_wlast   (s_wlast),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_bid     (s_bid),
      .s_bresp   (s_bresp),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .s_arid    (s_arid),
      .s_araddr  (s_araddr),
      .s_arlen   (s_arlen),
      .s_arsize  (s_arsize),
      .s_arburst (s_arburst),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_rid     (s_rid),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rlast   (s_rlast),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready)
   );

   always #5 clk = ~clk;

   // Counts cycles where the read channel was offered while a write was pending.
   always @(negedge clk) begin
      if (ar_watch && s_arready) ar_early++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
      int   w = 0;
      logic hs = 1'b0;
      s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awsize = 3'b010; s_awid = id;
      s_awvalid = 1'b1;
      while (!hs && w < 50) begin
         @(negedge clk); hs = s_awready;
         @(posedge clk); #1; w++;
      end
      s_awvalid = 1'b0;
      chk("aw_accept", {31'd0, hs}, 32'd1);
   endtask

   task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
      int   w = 0;
      logic hs = 1'b0;
      s_araddr = addr; s_arlen = len; s_arburst = burst; s_arsize = 3'b010; s_arid = id;
      s_arvalid = 1'b1;
      while (!hs && w < 50) begin
         @(negedge clk); hs = s_arready;
         @(posedge clk); #1; w++;
      end
      s_arvalid = 1'b0;
      chk("ar_accept", {31'd0, hs}, 32'd1);
   endtask

   task automatic w_phase(input int len, input logic [31:0] base, input logic [3:0] strb,
                          input int early);
      for (int i = 0; i <= len; i++) begin
         int   w = 0;
         logic hs = 1'b0;
         s_wdata = base + 32'(i); s_wstrb = strb;
         s_wlast = (early >= 0) ? (i == early) : (i == len);
         s_wvalid = 1'b1;
         while (!hs && w < 50) begin
            @(negedge clk); hs = s_wready;
            @(posedge clk); #1; w++;
         end
         if (!hs) begin
            chk("w_accept", {31'd0, hs}, 32'd1);
            break;
         end
      end
      s_wvalid = 1'b0; s_wlast = 1'b0;
   endtask

   task automatic b_phase();
      int   w = 0;
      logic hs = 1'b0;
      s_bready = 1'b1;
      while (!hs && w < 50) begin
         @(negedge clk); hs = s_bvalid;
         if (hs) begin b_resp = s_bresp; b_id = s_bid; end
         @(posedge clk); #1;
         if (!hs) w++;
      end
      s_bready = 1'b0;
      b_wait = w;
   endtask

   // mode 0: rready always high; mode 1: rready high every third cycle.
   task automatic r_phase(input int len, input int mode);
      int          k = 0;
      logic        stalled = 1'b0;
      logic [31:0] held = '0;
      rd_n = 0; rd_first = -1; rd_lastcyc = -1; rd_stall_err = 0; rd_extra = 0;
      while (rd_n < len + 1 && k < 200) begin
         s_rready = (mode == 0) ? 1'b1 : (k % 3 == 0);
         @(negedge clk);
         k++;
         if (s_rvalid) begin
            if (rd_first < 0) rd_first = k;
            if (stalled && s_rdata !== held) rd_stall_err++;
            if (s_rready) begin
               rd_data[rd_n] = s_rdata; rd_last[rd_n] = s_rlast;
               rd_resp[rd_n] = s_rresp; rd_id = s_rid;
               rd_n++; rd_lastcyc = k; stalled = 1'b0;
            end else begin
               stalled = 1'b1; held = s_rdata;
            end
         end
         @(posedge clk); #1;
      end
      s_rready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (s_rvalid) rd_extra++;
         @(posedge clk); #1;
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input logic [31:0] base, input logic [3:0] strb,
                            input int early);
      aw_phase(addr, len, burst, id);
      w_phase(int'(len), base, strb, early);
      b_phase();
      $display("WR addr=0x%08h len=%0d burst=%0d id=%0d bresp=%0d bid=%0d", addr, len, burst, id, b_resp, b_id);
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input int mode);
      ar_phase(addr, len, 2'b01, id);
      r_phase(int'(len), mode);
      $display("RD addr=0x%08h len=%0d id=%0d beats=%0d first=0x%08h rresp=%0d", addr, len, id, rd_n, rd_data[0], rd_resp[0]);
   endtask

   initial begin
      int li, lc;
      rst = 1'b1;
      s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
      s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
      s_rready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", {31'd0, s_awready}, 32'd0);
      chk("rst_arready", {31'd0, s_arready}, 32'd0);
      chk("rst_wready",  {31'd0, s_wready},  32'd0);
      chk("rst_bvalid",  {31'd0, s_bvalid},  32'd0);
      chk("rst_rvalid",  {31'd0, s_rvalid},  32'd0);
      chk("rst_rdata",   s_rdata, 32'd0);
      chk("rst_bresp",   {30'd0, s_bresp}, 32'd0);
      chk("rst_rresp",   {30'd0, s_rresp}, 32'd0);
      chk("rst_ids",     {24'd0, s_bid, s_rid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 16-beat write then read-back at full rate
      axi_write(32'h40, 8'd15, 2'b01, 4'h5, 32'h1000, 4'hF, -1);
      chk("wr_bresp", {30'd0, b_resp}, 32'd0);
      chk("wr_bid",   {28'd0, b_id},   32'd5);
      chk("wr_blat",  b_wait, 32'd0);
      axi_read(32'h40, 8'd15, 4'h9, 0);
      chk("rd_beats", rd_n, 32'd16);
      for (int i = 0; i < 16; i++) chk($sformatf("rd_data_%0d", i), rd_data[i], 32'h1000 + 32'(i));
      li = -1; lc = 0;
      for (int i = 0; i < rd_n; i++) if (rd_last[i]) begin li = i; lc++; end
      chk("rd_rlast_idx", li, 32'd15);
      chk("rd_rlast_cnt", lc, 32'd1);
      chk("rd_rid",   {28'd0, rd_id}, 32'd9);
      chk("rd_rresp", {30'd0, rd_resp[0]}, 32'd0);
      chk("rd_latency", rd_first, 32'd2);
      chk("rd_no_bubble", rd_lastcyc - rd_first, 32'd15);
      chk("rd_extra", rd_extra, 32'd0);

      // byte strobes
      axi_write(32'h200, 8'd0, 2'b01, 4'h1, 32'h11223344, 4'hF, -1);
      axi_write(32'h200, 8'd0, 2'b01, 4'h1, 32'hAABBCCDD, 4'b0101, -1);
      axi_read(32'h200, 8'd0, 4'h1, 0);
      chk("strb_data", rd_data[0], 32'h11BB33DD);
      chk("strb_rlast", {31'd0, rd_last[0]}, 32'd1);

      // backpressure
      axi_read(32'h40, 8'd3, 4'h2, 1);
      chk("bp_beats", rd_n, 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("bp_data_%0d", i), rd_data[i], 32'h1000 + 32'(i));
      chk("bp_stable", rd_stall_err, 32'd0);
      chk("bp_extra", rd_extra, 32'd0);
      chk("bp_rlast", {31'd0, rd_last[3]}, 32'd1);

      // simultaneous AW and AR: the write goes first
      s_awaddr = 32'h300; s_awlen = 8'd1; s_awburst = 2'b01; s_awsize = 3'b010; s_awid = 4'h3;
      s_araddr = 32'h300; s_arlen = 8'd1; s_arburst = 2'b01; s_arsize = 3'b010; s_arid = 4'hA;
      s_awvalid = 1'b1; s_arvalid = 1'b1; ar_watch = 1'b1;
      @(negedge clk);
      chk("sim_awready", {31'd0, s_awready}, 32'd1);
      chk("sim_arready", {31'd0, s_arready}, 32'd0);
      @(posedge clk); #1;
      s_awvalid = 1'b0;
      w_phase(1, 32'h5000, 4'hF, -1);
      b_phase();
      ar_watch = 1'b0;
      $display("WR addr=0x00000300 len=1 (with AR pending) bresp=%0d bid=%0d", b_resp, b_id);
      chk("sim_bresp", {30'd0, b_resp}, 32'd0);
      chk("sim_ar_early", ar_early, 32'd0);
      ar_phase(32'h300, 8'd1, 2'b01, 4'hA);
      r_phase(1, 0);
      $display("RD addr=0x00000300 len=1 (after write) beats=%0d first=0x%08h", rd_n, rd_data[0]);
      chk("sim_rd0", rd_data[0], 32'h5000);
      chk("sim_rd1", rd_data[1], 32'h5001);
      chk("sim_rid", {28'd0, rd_id}, 32'hA);

      // out-of-range read
      axi_read(32'h4000, 8'd1, 4'h2, 0);
      chk("oor_beats", rd_n, 32'd2);
      chk("oor_resp0", {30'd0, rd_resp[0]}, 32'd2);
      chk("oor_resp1", {30'd0, rd_resp[1]}, 32'd2);
      chk("oor_data0", rd_data[0], 32'd0);
      chk("oor_data1", rd_data[1], 32'd0);

      // WRAP burst type is rejected and leaves RAM untouched
      axi_write(32'h40, 8'd0, 2'b10, 4'h4, 32'hDEADBEEF, 4'hF, -1);
      chk("wrap_bresp", {30'd0, b_resp}, 32'd2);
      chk("wrap_bid",   {28'd0, b_id},   32'd4);
      axi_read(32'h40, 8'd0, 4'h4, 0);
      chk("wrap_ram", rd_data[0], 32'h1000);

      // wlast asserted early on the second beat of a 4-beat burst
      axi_write(32'h80, 8'd3, 2'b01, 4'h6, 32'h7000, 4'hF, 1);
      chk("wlast_bresp", {30'd0, b_resp}, 32'd2);

      // word index wraps past the top of memory
      axi_write(32'h3FFC, 8'd1, 2'b01, 4'h1, 32'h9000, 4'hF, -1);
      chk("top_bresp", {30'd0, b_resp}, 32'd0);
      axi_read(32'h0, 8'd0, 4'h1, 0);
      chk("top_wrap_w0", rd_data[0], 32'h9001);
      axi_read(32'h3FFC, 8'd1, 4'h1, 0);
      chk("top_rd0", rd_data[0], 32'h9000);
      chk("top_rd1", rd_data[1], 32'h9001);

      // unaligned address is treated as word aligned
      axi_read(32'h42, 8'd0, 4'h1, 0);
      chk("unal_data", rd_data[0], 32'h1000);
      chk("unal_resp", {30'd0, rd_resp[0]}, 32'd0);

      // asynchronous reset in the middle of a stalled read burst
      ar_phase(32'h40, 8'd15, 2'b01, 4'h7);
      s_rready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_rvalid", {31'd0, s_rvalid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      $display("RST asserted mid-burst rvalid=%0d arready=%0d awready=%0d", s_rvalid, s_arready, s_awready);
      chk("mid_rst_rvalid",  {31'd0, s_rvalid},  32'd0);
      chk("mid_rst_arready", {31'd0, s_arready}, 32'd0);
      chk("mid_rst_awready", {31'd0, s_awready}, 32'd0);
      chk("mid_rst_rlast",   {31'd0, s_rlast},   32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      axi_read(32'h40, 8'd1, 4'h8, 0);
      chk("post_rst_rd0", rd_data[0], 32'h1000);
      chk("post_rst_rd1", rd_data[1], 32'h1001);
      chk("post_rst_rid", {28'd0, rd_id}, 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
